io_conditioner: RTL

- Parametrised I/O front end that sits directly behind the pad buffers and in front of the UART and user logic.
- Every raw input (buttons, switches, RX) passes through a multi-stage synchronizer and a per-channel debounce filter. Each channel produces a clean level plus one-cycle rise and fall strobes.
- Outputs (LEDs, TX-side indicators) are driven from a write-enabled output register with a defined reset value, so pads never float or glitch out of reset.

---
 rtl/io_conditioner_if.sv | 34 +++
 rtl/io_conditioner.sv | 94 +++++++++
 2 files changed

// File: rtl/io_conditioner_if.sv
// Signal bundle between the pad-side I/O conditioner and its consumers.
// The slave modport is the conditioner; the master modport is the user logic or the bench.
interface io_conditioner_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8
);
    logic [N_IN-1:0]  in_raw_i;
    logic [N_IN-1:0]  in_level_o;
    logic [N_IN-1:0]  in_rise_o;
    logic [N_IN-1:0]  in_fall_o;
    logic [N_OUT-1:0] out_d_i;
    logic             out_we_i;
    logic [N_OUT-1:0] out_o;

    modport slave (
        input  in_raw_i,
        input  out_d_i,
        input  out_we_i,
        output in_level_o,
        output in_rise_o,
        output in_fall_o,
        output out_o
    );

    modport master (
        output in_raw_i,
        output out_d_i,
        output out_we_i,
        input  in_level_o,
        input  in_rise_o,
        input  in_fall_o,
        input  out_o
    );
endinterface

// File: rtl/io_conditioner.sv
// Pad-side input synchronizer + per-channel debounce with edge strobes,
// and a write-enabled output register with a defined reset value.
module io_conditioner #(
    parameter int               N_IN        = 8,
    parameter int               N_OUT       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEB_CYCLES  = 4,
    parameter logic [N_IN-1:0]  IN_RST_VAL  = '0,
    parameter logic [N_OUT-1:0] OUT_RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    io_conditioner_if.slave  io
);

    localparam int             CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [N_IN-1:0]  sync_q [SYNC_STAGES];
    logic [N_IN-1:0]  sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [N_IN];
    logic [CW-1:0]    cnt_d  [N_IN];
    logic [N_IN-1:0]  level_q, level_d;
    logic [N_IN-1:0]  rise_q, rise_d;
    logic [N_IN-1:0]  fall_q, fall_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  sync_c;

    // First stage sees only the raw pad; nothing else samples it.
    always_comb begin
        sync_d[0] = io.in_raw_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_c = sync_q[SYNC_STAGES-1];

    // Any cycle matching the accepted level restarts the count, so a bounce
    // shorter than DEB_CYCLES never reaches the accept compare.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int c = 0; c < N_IN; c++) begin
            cnt_d[c] = '0;
            if (sync_c[c] != level_q[c]) begin
                if (cnt_q[c] == CNT_LAST) begin
                    level_d[c] = sync_c[c];
                    rise_d[c]  = sync_c[c];
                    fall_d[c]  = ~sync_c[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        out_d = io.out_we_i ? io.out_d_i : out_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= IN_RST_VAL;
            end
            for (int c = 0; c < N_IN; c++) begin
                cnt_q[c] <= '0;
            end
            level_q <= IN_RST_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            out_q   <= OUT_RST_VAL;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int c = 0; c < N_IN; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            out_q   <= out_d;
        end
    end

    assign io.in_level_o = level_q;
    assign io.in_rise_o  = rise_q;
    assign io.in_fall_o  = fall_q;
    assign io.out_o      = out_q;

endmodule
